// File: rtl/fsm_edge_detect_multi_if.sv
// Bundle for fsm_edge_detect_multi: per-channel inputs and edge outputs.
// master drives din/edge_sel (and cnt_clr when EDGE_CNT_EN); slave is the detector.
interface fsm_edge_detect_multi_if #(
  parameter int N = 4
) ();
  logic [N-1:0]   din;
  logic [2*N-1:0] edge_sel;
  logic [N-1:0]   pulse;
  logic [N-1:0]   level;
  logic           any_pulse;
`ifdef EDGE_CNT_EN
  logic [N-1:0]   cnt_clr;
  logic [8*N-1:0] edge_cnt;

  modport master (
    output din, edge_sel, cnt_clr,
    input  pulse, level, any_pulse, edge_cnt
  );
  modport slave (
    input  din, edge_sel, cnt_clr,
    output pulse, level, any_pulse, edge_cnt
  );
`else
  modport master (
    output din, edge_sel,
    input  pulse, level, any_pulse
  );
  modport slave (
    input  din, edge_sel,
    output pulse, level, any_pulse
  );
`endif
endinterface

// File: rtl/fsm_edge_detect_multi.sv
// N-channel glitch-filtered edge detector, Moore or Mealy pulse timing.
// Ports: clk, rst (async active-low), bus.slave: din, edge_sel in; pulse,
// level, any_pulse out. Macro EDGE_CNT_EN adds cnt_clr in / edge_cnt out.
module fsm_edge_detect_multi #(
  parameter int N     = 4,
  parameter int FILT  = 0,
  parameter int MOORE = 1
) (
  input logic clk,
  input logic rst,
  fsm_edge_detect_multi_if.slave bus
);
  localparam int CW = (FILT < 1) ? 1 : $clog2(FILT + 1);
  localparam logic [CW-1:0] FMAX = CW'(FILT);

  localparam logic [1:0] S_LOW  = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_FALL = 2'd3;

  logic [N-1:0][1:0]    st_q, st_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]         lvl, acc, pul;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    lvl   = '0;
    acc   = '0;
    pul   = '0;
    for (int i = 0; i < N; i++) begin
      lvl[i] = (st_q[i] == S_RISE) ||
               (st_q[i] == S_HIGH);
      acc[i] = (bus.din[i] != lvl[i]) &&
               (cnt_q[i] == FMAX);
      // counter restarts on accept or whenever din matches level
      if ((bus.din[i] == lvl[i]) || acc[i])
        cnt_d[i] = '0;
      else
        cnt_d[i] = cnt_q[i] + 1'b1;
      case (st_q[i])
        S_LOW:   st_d[i] = acc[i] ? S_RISE : S_LOW;
        S_RISE:  st_d[i] = acc[i] ? S_FALL : S_HIGH;
        S_HIGH:  st_d[i] = acc[i] ? S_FALL : S_HIGH;
        default: st_d[i] = acc[i] ? S_RISE : S_LOW;
      endcase
      if (MOORE != 0)
        pul[i] = ((st_q[i] == S_RISE) &&
                  bus.edge_sel[2*i]) ||
                 ((st_q[i] == S_FALL) &&
                  bus.edge_sel[2*i+1]);
      else
        // gated by rst: accept is combinational and
        // can be high while the state is held in reset
        pul[i] = rst && acc[i] &&
                 ((!lvl[i] && bus.edge_sel[2*i]) ||
                  (lvl[i] && bus.edge_sel[2*i+1]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= {N{S_LOW}};
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.pulse     = pul;
  assign bus.level     = lvl;
  assign bus.any_pulse = |pul;

`ifdef EDGE_CNT_EN
  logic [N-1:0][7:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    for (int i = 0; i < N; i++) begin
      if (bus.cnt_clr[i])
        ecnt_d[i] = '0;
      else if (pul[i] && (ecnt_q[i] != 8'hff))
        ecnt_d[i] = ecnt_q[i] + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ecnt_q <= '0;
    else      ecnt_q <= ecnt_d;
  end

  assign bus.edge_cnt = ecnt_q;
`endif
endmodule

// File: doc/fsm_edge_detect_multi.md
Name: fsm_edge_detect_multi

Overview:
Parametrised multi-channel successor to the single-bit dual-edge detector. Each of N independent channels has a glitch filter and a 4-state edge FSM. Each channel produces a one-cycle pulse on a per-channel selectable edge type: none, rising, falling or both. A parameter selects Moore (registered) or Mealy (early, combinational) pulse timing, so one block serves every edge-detect user in the design.

Parameters:
N, 4, number of independent channels (>=1)
FILT, 0, extra consecutive cycles din must hold a new value before the edge is accepted (0 = no filtering)
MOORE, 1, 1 = pulse decoded from FSM state (registered timing); 0 = Mealy pulse decoded from accept condition (one cycle earlier)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
din  input  N  channel inputs, already synchronous to clk
edge_sel  input  2N  per channel i, bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both
pulse  output  N  one-cycle edge pulse per channel
level  output  N  filtered (accepted) level per channel
any_pulse  output  1  OR of pulse[N-1:0]

Behaviour:
- Reset (rst=0, asynchronous):
  - All FSMs go to LOW; filter counters clear to 0.
  - level=0, pulse=0, any_pulse=0; Mealy outputs are forced to 0 while rst=0.
- Filter, per channel:
  - Counter width CW = max(1, $clog2(FILT+1)).
  - diff = din[i] != level[i].
  - If !diff: cnt <= 0.
  - If diff and cnt==FILT: accept=1, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A new value must therefore be present for FILT+1 consecutive cycles.
  - A glitch of <=FILT cycles produces no accept and no pulse; the counter restarts whenever diff drops.
- FSM per channel, states LOW, RISE, HIGH, FALL. level=1 in RISE and HIGH.
  - LOW: accept -> RISE; else stay.
  - RISE: accept -> FALL; else -> HIGH. RISE lasts exactly one cycle.
  - HIGH: accept -> FALL; else stay.
  - FALL: accept -> RISE; else -> LOW. FALL lasts exactly one cycle.
  - Back-to-back accepts (only possible with FILT=0 and a toggling din) yield alternating RISE/FALL, one pulse per edge; no edge is dropped.
- Pulse:
  - Moore: pulse[i] = (state==RISE & sel[0]) | (state==FALL & sel[1]).
  - Mealy: pulse[i] = accept & ((!level & sel[0]) | (level & sel[1])).
- Latency: cycle 0 is the first cycle din differs from level. Mealy pulse in cycle FILT; Moore pulse in cycle FILT+1. level updates in cycle FILT+1 in both modes.
- edge_sel is applied combinationally to the output only. Changing it never alters FSM or filter state. A pulse masked at its cycle is lost and is not replayed.
- Reset mid-operation: pending filter counts and in-flight RISE/FALL are discarded.
- din held at 1 across reset release: a rising edge is reported FILT+1 cycles after reset release (Mealy) / FILT+2 (Moore). This behaviour is intended.
- Channels are fully independent; simultaneous edges on several channels each pulse in the same cycle.

Optional Feature:
Macro EDGE_CNT_EN.
- Defined:
  - Adds input cnt_clr (N) and output edge_cnt (8N).
  - Per channel an 8-bit counter increments on every cycle pulse[i]=1 and saturates at 255.
  - cnt_clr[i]=1 clears it to 0 and has priority over a coincident increment.
  - Reset value 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- N=4, FILT=0, MOORE=1, edge_sel=all 11: din[0] 0->1 seen in cycle 0 -> pulse[0]=1 in cycle 1 only, level[0]=1 from cycle 1; din[0] 1->0 -> pulse again one cycle later; any_pulse mirrors pulse.
- FILT=3, MOORE=1, edge_sel ch1=01: a 3-cycle high glitch -> no pulse and level stays 0; a 4-cycle high -> pulse[1] in cycle 4; the return to 0 (4+ cycles) produces no pulse (falling masked) but level[1] returns to 0.
- MOORE=0, FILT=2: din[2] rises in cycle 0 -> pulse[2]=1 in cycle 2 (combinational), level[2]=1 in cycle 3.
- FILT=0, din[3] toggling every cycle for 6 cycles, edge_sel=11 -> 6 consecutive pulse cycles and FSM alternating RISE/FALL.
- Assert rst=0 asynchronously mid-filter (cnt=2, FILT=3) with din=1 held -> outputs 0 immediately; after release a pulse appears exactly FILT+2=5 cycles later (Moore).
- EDGE_CNT_EN: 300 rising edges on ch0 -> edge_cnt[7:0]=255; cnt_clr[0]=1 coincident with a pulse -> edge_cnt[7:0]=0 next cycle.
